tile_flusher: RTL
=================

# tile_flusher

Downstream consumer of the tile painter. Once a 20×45 tile has been rasterised into the tile BRAM, this block streams all 900 pixel words, in raster order, to the 320×180 framebuffer write port. Untouched (wiped) pixels are replaced with a background colour. It carries a valid/ready handshake with an internal skid FIFO that absorbs the 2-cycle tile BRAM read latency. It pulses `done` so the top level can assert the painter's `wipe` and advance to the next tile.

## Interface
Parameters:
- `TILE_W`, 20, tile width in pixels
- `TILE_H`, 45, tile height in pixels
- `FB_WIDTH`, 320, framebuffer row pitch in pixels
- `BG_COLOR`, 16'h0000, colour written for unpainted pixels

Ports:
- `clk`  in  1  single system clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin flushing one tile; sampled only in IDLE
- `x_offset`  in  9  x of the tile's top-left pixel; latched on accepted `start`
- `y_offset`  in  8  y of the tile's top-left pixel; latched on accepted `start`
- `tile_bram_read_addr`  out  10  tile BRAM address, y*20+x
- `tile_bram_read_data`  in  32  tile BRAM data, valid 2 cycles after the address; [31:16] depth, [15:0] RGB565
- `fb_write_addr`  out  16  framebuffer address
- `fb_write_data`  out  16  RGB565 pixel
- `fb_write_valid`  out  1  write request
- `fb_write_ready`  in  1  framebuffer accepts the write this cycle
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the 900th write is accepted

## Operation
States:
- **IDLE**: `start` latches offsets, zeroes the read counter, and moves to READING.
- **READING**: issues reads at addr 0..899 per the issue rule. Moves to DRAINING on the cycle after addr 899 is issued.
- **DRAINING**: waits until the write counter reaches 900.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.

Read issue and buffering:
- A read is issued in a cycle iff state is READING and `fifo_count + inflight < 4`. `inflight` (0–2) counts reads whose data has not yet returned.
- The read counter advances only on an issued read. `tile_bram_read_addr` holds its value otherwise.
- A 2-bit valid pipeline tracks issued reads. Returning data is pushed into a 4-entry FIFO together with its tile-local (x, y). The FIFO never overflows by construction.

Pixel mapping:
- If the data word == 32'hFFFFFFFF, `fb_write_data` = `BG_COLOR`; otherwise `fb_write_data` = data[15:0].
- `fb_write_addr` = (y_offset_l + y) * FB_WIDTH + (x_offset_l + x), computed to 17 bits and truncated to 16. Max legal address is 57599.
- Raster order within the tile: x fastest, 0..19, then y 0..44.

Handshake:
- `fb_write_valid` = FIFO non-empty. Address and data are the FIFO head.
- A transfer occurs when valid && ready. The head pops, and the write counter (0–900) increments.
- Address and data hold stable while valid && !ready.

## Timing
- Reset values: `tile_bram_read_addr`=0, `fb_write_addr`=0, `fb_write_data`=0, `fb_write_valid`=0, `busy`=0, `done`=0. State is IDLE, FIFO empty, `inflight`=0, counters 0.
- `start` accepted at cycle T: addr 0 is presented at T+1, its data returns at T+3, and `fb_write_valid` rises at T+4.
- With `fb_write_ready` held high, writes complete one per cycle over T+4..T+903, and `done` is high at T+904. Total is 905 cycles start to done.
- When ready drops, at most 4 reads are outstanding. Issue resumes the cycle after the FIFO pops. There is no loss and no duplication.
- `start` while busy is ignored. `start` during DONE is ignored, so it can be accepted at the earliest on the following IDLE cycle.
- `rst` at any point: all state returns to reset values the next cycle. FIFO contents and in-flight data are discarded, and `done` is not pulsed.
- An offset change after `start` has no effect until the next `start`.

## Test plan
- **Full tile, ready=1:** offsets (0,0), BRAM word = {16'h0, idx}. Require 900 writes at addr 0..19, 320..339, …; data = idx; `done` at T+904.
- **Background substitution:** BRAM filled with 32'hFFFFFFFF except idx 21 = 32'h1234ABCD, BG_COLOR=16'h001F. Require idx 21 → addr 321, data 16'hABCD; every other pixel data 16'h001F.
- **Last tile offsets:** x_offset=300, y_offset=135. Require the first addr to be 43500 and the last addr to be 57599.
- **Backpressure:** ready toggles randomly, including a 50-cycle low stretch mid-tile. Require exactly 900 writes, in raster order, with address and data stable while stalled, and `tile_bram_read_addr` frozen once `fifo_count + inflight` reaches 4.
- **Reset mid-flush:** assert `rst` after 400 writes. Require all outputs to be 0 the next cycle and no `done`. A new `start` then produces a full 900-write sequence from addr base+0.
- **Start while busy:** pulse `start` with new offsets at write 100. Require it to be ignored: the original offsets are used throughout and there is only one `done`.

Source files
------------

// File: rtl/tile_flusher_if.sv
// Framebuffer write port: valid/ready handshake carrying one RGB565 pixel
// and its framebuffer address.
interface tile_flusher_if;
   logic [15:0] fb_write_addr;
   logic [15:0] fb_write_data;
   logic        fb_write_valid;
   logic        fb_write_ready;

   modport master (
      output fb_write_addr,
      output fb_write_data,
      output fb_write_valid,
      input  fb_write_ready
   );

   modport slave (
      input  fb_write_addr,
      input  fb_write_data,
      input  fb_write_valid,
      output fb_write_ready
   );
endinterface

// File: rtl/tile_flusher.sv
// Streams a rasterised tile from the tile BRAM to the framebuffer in raster
// order, substituting the background colour for wiped pixels.
module tile_flusher #(
   parameter int unsigned TILE_W   = 20,
   parameter int unsigned TILE_H   = 45,
   parameter int unsigned FB_WIDTH = 320,
   parameter logic [15:0] BG_COLOR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  x_offset,
   input  logic [7:0]  y_offset,
   output logic [9:0]  tile_bram_read_addr,
   input  logic [31:0] tile_bram_read_data,
   tile_flusher_if.master fb,
   output logic        busy,
   output logic        done
);

   localparam int unsigned NPIX = TILE_W * TILE_H;
   localparam int unsigned XW   = $clog2(TILE_W);
   localparam int unsigned YW   = $clog2(TILE_H);

   typedef enum logic [1:0] {S_IDLE, S_READING, S_DRAINING, S_DONE} state_t;
   state_t state, state_nx;

   logic [8:0]    x_off_l;
   logic [7:0]    y_off_l;
   logic [9:0]    rd_cnt;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic [9:0]    wr_cnt;

   logic [1:0]    vld_pipe;
   logic [15:0]   addr_p0, addr_p1;
   logic [1:0]    inflight;

   logic [31:0]   fifo_mem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    fifo_count;

   logic          issue, last_issue, push, pop, fifo_valid;
   logic [8:0]    y_sum;
   logic [9:0]    x_sum;
   logic [15:0]   pix_addr;
   logic [15:0]   push_data;

   always_comb begin
      inflight   = {1'b0, vld_pipe[0]} + {1'b0, vld_pipe[1]};
      // Issue only when the FIFO is guaranteed room for every outstanding read.
      issue      = (state == S_READING) && ((fifo_count + {1'b0, inflight}) < 3'd4);
      last_issue = issue && (rd_cnt == 10'(NPIX - 1));
      push       = vld_pipe[1];
      fifo_valid = (fifo_count != 3'd0);
      pop        = fifo_valid && fb.fb_write_ready;
      y_sum      = {1'b0, y_off_l} + 9'(rd_y);
      x_sum      = {1'b0, x_off_l} + 10'(rd_x);
      pix_addr   = 16'(17'(y_sum) * 17'(FB_WIDTH) + 17'(x_sum));
      push_data  = (tile_bram_read_data == '1) ? BG_COLOR : tile_bram_read_data[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
      unique case (state)
         S_IDLE:     if (start) state_nx = S_READING;
         S_READING:  if (last_issue) state_nx = S_DRAINING;
         S_DRAINING: if ((wr_cnt + 10'(pop)) == 10'(NPIX)) state_nx = S_DONE;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_off_l    <= '0;
         y_off_l    <= '0;
         rd_cnt     <= '0;
         rd_x       <= '0;
         rd_y       <= '0;
         wr_cnt     <= '0;
         vld_pipe   <= '0;
         addr_p0    <= '0;
         addr_p1    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            x_off_l <= x_offset;
            y_off_l <= y_offset;
            rd_cnt  <= '0;
            rd_x    <= '0;
            rd_y    <= '0;
            wr_cnt  <= '0;
         end
         // The address parks on the final pixel once the tile is fully issued.
         if (issue) begin
            if (!last_issue) rd_cnt <= rd_cnt + 10'd1;
            if (rd_x == XW'(TILE_W - 1)) begin
               rd_x <= '0;
               rd_y <= rd_y + YW'(1);
            end else begin
               rd_x <= rd_x + XW'(1);
            end
         end
         vld_pipe <= {vld_pipe[0], issue};
         addr_p0  <= pix_addr;
         addr_p1  <= addr_p0;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
            wr_cnt <= wr_cnt + 10'd1;
         end
         fifo_count <= fifo_count + 3'(push) - 3'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {addr_p1, push_data};
   end

   always_comb begin
      tile_bram_read_addr = rd_cnt;
      fb.fb_write_valid   = fifo_valid;
      fb.fb_write_addr    = fifo_valid ? fifo_mem[rd_ptr][31:16] : '0;
      fb.fb_write_data    = fifo_valid ? fifo_mem[rd_ptr][15:0]  : '0;
   end

endmodule
